// File: rtl/universal_shift_pkg.sv
// Shared opcodes, FSM encoding and small helpers for the universal shift unit.
package universal_shift_pkg;

    localparam logic [2:0] OP_HOLD = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_SRL  = 3'b010;
    localparam logic [2:0] OP_SLL  = 3'b011;
    localparam logic [2:0] OP_ROR  = 3'b100;
    localparam logic [2:0] OP_ROL  = 3'b101;
    localparam logic [2:0] OP_ADD  = 3'b110;
    localparam logic [2:0] OP_CLR  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    // Opcodes 010..101 are the multi-cycle shift/rotate family.
    function automatic logic is_shift(input logic [2:0] op);
        return (op == OP_SRL) || (op == OP_SLL) || (op == OP_ROR) || (op == OP_ROL);
    endfunction

endpackage

// File: rtl/universal_shift_unit_shift_step.sv
// One-position shift/rotate step; non-shift opcodes pass the register through.
module shift_step
    import universal_shift_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic             ser_i,
    input  logic             carry_i,
    output logic [WIDTH-1:0] d_o,
    output logic             carry_o
);

    always_comb begin
        d_o     = d_i;
        carry_o = carry_i;
        case (op_i)
            OP_SRL: begin
                d_o     = {ser_i, d_i[WIDTH-1:1]};
                carry_o = d_i[0];
            end
            OP_SLL: begin
                d_o     = {d_i[WIDTH-2:0], ser_i};
                carry_o = d_i[WIDTH-1];
            end
            OP_ROR: begin
                d_o     = {d_i[0], d_i[WIDTH-1:1]};
                carry_o = d_i[0];
            end
            OP_ROL: begin
                d_o     = {d_i[WIDTH-2:0], d_i[WIDTH-1]};
                carry_o = d_i[WIDTH-1];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/universal_shift_unit.sv
// Universal register: single-cycle load/add/clear plus bit-serial shift/rotate
// sequenced by a three-state FSM behind a valid/ready command port.
module universal_shift_unit
    import universal_shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [2:0]       sel_i,
    input  logic [AMT_W-1:0] amt_i,
    input  logic [WIDTH-1:0] d_in_i,
    input  logic             ser_in_i,
    input  logic             abort_i,
    output logic [WIDTH-1:0] d_out_o,
    output logic             carry_o,
    output logic             zero_o,
    output logic             busy_o,
    output logic             done_o
);

    state_e           state_q;
    logic [AMT_W-1:0] cnt_q;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] d_q, d_d;
    logic             c_q, c_d;
    logic             ready_q, busy_q, done_q;

    logic [WIDTH-1:0] step_d;
    logic             step_c;
    logic [WIDTH:0]   sum;
    logic [AMT_W-1:0] amt_clamped;
    logic             accept;

    assign accept      = (state_q == ST_IDLE) && cmd_valid_i;
    assign sum         = {1'b0, d_q} + {1'b0, d_in_i};
    assign amt_clamped = (amt_i > AMT_W'(WIDTH)) ? AMT_W'(WIDTH) : amt_i;

    shift_step #(.WIDTH(WIDTH)) u_step (
        .op_i    (op_q),
        .d_i     (d_q),
        .ser_i   (ser_in_i),
        .carry_i (c_q),
        .d_o     (step_d),
        .carry_o (step_c)
    );

    // Single-cycle ops commit on the accept edge; shifts only latch the count
    // on accept and move data one position per SHIFT cycle.
    always_comb begin
        d_d = d_q;
        c_d = c_q;
        if (accept) begin
            case (sel_i)
                OP_LOAD: begin
                    d_d = d_in_i;
                    c_d = 1'b0;
                end
                OP_ADD: {c_d, d_d} = sum;
                OP_CLR: begin
                    d_d = '0;
                    c_d = 1'b0;
                end
                default: ;
            endcase
        end else if (state_q == ST_SHIFT && !abort_i) begin
            d_d = step_d;
            c_d = step_c;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= OP_HOLD;
            d_q     <= '0;
            c_q     <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            d_q    <= d_d;
            c_q    <= c_d;
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid_i) begin
                        op_q    <= sel_i;
                        ready_q <= 1'b0;
                        if (is_shift(sel_i) && amt_clamped != '0) begin
                            cnt_q   <= amt_clamped;
                            state_q <= ST_SHIFT;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                ST_SHIFT: begin
                    cnt_q <= cnt_q - AMT_W'(1);
                    if (abort_i || cnt_q == AMT_W'(1)) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign d_out_o     = d_q;
    assign carry_o     = c_q;
    assign zero_o      = (d_q == '0);
    assign cmd_ready_o = ready_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_universal_shift_unit.sv
// Directed and randomized checks of universal_shift_unit against a behavioural model.
module tb_universal_shift_unit;

    localparam int W = 8;
    localparam int H = 0, LD = 1, SRL = 2, SLL = 3, ROR = 4, ROL = 5, ADD = 6, CLR = 7;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       cmd_valid_i = 1'b0;
    logic       cmd_ready_o;
    logic [2:0] sel_i = 3'd0;
    logic [3:0] amt_i = 4'd0;
    logic [7:0] d_in_i = 8'd0;
    logic       ser_in_i = 1'b0;
    logic       abort_i = 1'b0;
    logic [7:0] d_out_o;
    logic       carry_o, zero_o, busy_o, done_o;

    int n_pass = 0;
    int n_total = 0;

    universal_shift_unit #(.WIDTH(W)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .sel_i(sel_i), .amt_i(amt_i), .d_in_i(d_in_i), .ser_in_i(ser_in_i), .abort_i(abort_i),
        .d_out_o(d_out_o), .carry_o(carry_o), .zero_o(zero_o), .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: value/carry as integers, plus "steps left" and "done pending".
    int m_v = 0, m_c = 0, m_left = 0, m_done = 0, m_op = 0;

    function automatic int step(input int op, input int v, input int s, input int c);
        int nv, nc;
        nv = v; nc = c;
        case (op)
            SRL: begin nc = v & 1;        nv = (v >> 1) | (s << (W-1)); end
            SLL: begin nc = (v >> 7) & 1; nv = ((v << 1) & 255) | s; end
            ROR: begin nc = v & 1;        nv = (v >> 1) | ((v & 1) << (W-1)); end
            ROL: begin nc = (v >> 7) & 1; nv = ((v << 1) & 255) | ((v >> 7) & 1); end
            default: ;
        endcase
        return (nc << 8) | nv;
    endfunction

    always @(posedge clk_i) begin
        int r, s, n;
        if (!rst_ni) begin
            m_v = 0; m_c = 0; m_left = 0; m_done = 0;
        end else if (m_done != 0) begin
            m_done = 0;
        end else if (m_left > 0) begin
            if (abort_i) begin
                m_left = 0; m_done = 1;
            end else begin
                r = step(m_op, m_v, int'(ser_in_i), m_c);
                m_v = r & 255; m_c = r >> 8;
                m_left--;
                if (m_left == 0) m_done = 1;
            end
        end else if (cmd_valid_i) begin
            m_done = 1;
            case (int'(sel_i))
                LD:  begin m_v = int'(d_in_i); m_c = 0; end
                ADD: begin s = m_v + int'(d_in_i); m_v = s & 255; m_c = s >> 8; end
                CLR: begin m_v = 0; m_c = 0; end
                SRL, SLL, ROR, ROL: begin
                    n = (int'(amt_i) > W) ? W : int'(amt_i);
                    m_op = int'(sel_i);
                    if (n > 0) begin m_left = n; m_done = 0; end
                end
                default: ;
            endcase
        end
    end

    always @(posedge clk_i) begin
        #2;
        chk("d_out", int'(d_out_o), m_v);
        chk("carry", int'(carry_o), m_c);
        chk("zero", int'(zero_o), (m_v == 0) ? 1 : 0);
        chk("busy", int'(busy_o), (m_left > 0) ? 1 : 0);
        chk("cmd_ready", int'(cmd_ready_o), (m_left == 0 && m_done == 0) ? 1 : 0);
        chk("done", int'(done_o), m_done);
    end

    // Returns at the negedge after the accept edge.
    task automatic issue(input int sel, input int amt, input int din, input int ser);
        int k;
        k = 0;
        @(negedge clk_i);
        while (!cmd_ready_o && k < 40) begin @(negedge clk_i); k++; end
        if (!cmd_ready_o) chk("ready_timeout", 0, 1);
        cmd_valid_i = 1'b1; sel_i = 3'(sel); amt_i = 4'(amt); d_in_i = 8'(din); ser_in_i = 1'(ser);
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
    endtask

    task automatic wait_done(output int busy_cycles);
        int k;
        k = 0; busy_cycles = 0;
        while (!done_o && k < 40) begin
            if (busy_o) busy_cycles++;
            @(negedge clk_i); k++;
        end
        if (!done_o) chk("done_timeout", 0, 1);
    endtask

    initial begin
        int bc;
        // T1: reset state, then LOAD
        @(negedge clk_i);
        chk("rst_d_out", int'(d_out_o), 0);
        chk("rst_carry", int'(carry_o), 0);
        chk("rst_zero", int'(zero_o), 1);
        chk("rst_ready", int'(cmd_ready_o), 1);
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_done", int'(done_o), 0);
        @(negedge clk_i); rst_ni = 1'b1;
        issue(LD, 0, 'hA5, 0);
        chk("t1_load", int'(d_out_o), 'hA5);
        chk("t1_done", int'(done_o), 1);
        chk("t1_carry", int'(carry_o), 0);
        chk("t1_zero", int'(zero_o), 0);
        @(negedge clk_i);
        chk("t1_done_pulse", int'(done_o), 0);
        // T2: rotates
        issue(LD, 0, 'h81, 0); wait_done(bc);
        issue(ROR, 1, 0, 0); wait_done(bc);
        chk("t2_ror", int'(d_out_o), 'hC0);
        chk("t2_ror_c", int'(carry_o), 1);
        issue(LD, 0, 'h81, 0); wait_done(bc);
        issue(ROL, 3, 0, 0); wait_done(bc);
        chk("t2_rol", int'(d_out_o), 'h0C);
        chk("t2_rol_c", int'(carry_o), 0);
        chk("t2_busy_cycles", bc, 3);
        // T3: serial fill, clamped amount
        issue(CLR, 0, 0, 0); wait_done(bc);
        issue(SRL, 4, 0, 1); wait_done(bc);
        chk("t3_srl", int'(d_out_o), 'hF0);
        chk("t3_srl_c", int'(carry_o), 0);
        issue(LD, 0, 'hFF, 0); wait_done(bc);
        issue(SLL, 12, 0, 0); wait_done(bc);
        chk("t3_sll", int'(d_out_o), 0);
        chk("t3_sll_c", int'(carry_o), 1);
        chk("t3_steps", bc, 8);
        // T4: add with carry
        issue(LD, 0, 'hF0, 0); wait_done(bc);
        issue(ADD, 0, 'h20, 0);
        chk("t4_add1", int'(d_out_o), 'h10);
        chk("t4_add1_c", int'(carry_o), 1);
        issue(ADD, 0, 'hF0, 0);
        chk("t4_add2", int'(d_out_o), 0);
        chk("t4_add2_c", int'(carry_o), 1);
        chk("t4_zero", int'(zero_o), 1);
        // T5: amt==0 keeps value and carry; full rotate restores
        issue(SRL, 0, 0, 1);
        chk("t5_amt0_done", int'(done_o), 1);
        chk("t5_amt0_v", int'(d_out_o), 0);
        chk("t5_amt0_c", int'(carry_o), 1);
        issue(LD, 0, 'h3C, 0); wait_done(bc);
        issue(ROL, 8, 0, 0); wait_done(bc);
        chk("t5_rol8", int'(d_out_o), 'h3C);
        // T6: commands ignored while busy, abort keeps partial result
        issue(LD, 0, 'hA5, 0); wait_done(bc);
        issue(SRL, 6, 0, 0);
        cmd_valid_i = 1'b1; sel_i = 3'(LD); d_in_i = 8'h11;
        @(negedge clk_i);
        @(negedge clk_i);
        abort_i = 1'b1; cmd_valid_i = 1'b0;
        @(negedge clk_i);
        abort_i = 1'b0;
        chk("t6_abort_done", int'(done_o), 1);
        chk("t6_abort_v", int'(d_out_o), 'h29);
        chk("t6_abort_c", int'(carry_o), 0);
        issue(LD, 0, 'hFF, 0); wait_done(bc);
        issue(SRL, 6, 0, 1);
        @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        chk("t6_rst_v", int'(d_out_o), 0);
        chk("t6_rst_c", int'(carry_o), 0);
        chk("t6_rst_zero", int'(zero_o), 1);
        chk("t6_rst_busy", int'(busy_o), 0);
        chk("t6_rst_done", int'(done_o), 0);
        chk("t6_rst_ready", int'(cmd_ready_o), 1);
        @(negedge clk_i); rst_ni = 1'b1;
        // Randomized traffic, checked every cycle by the model
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk_i);
            cmd_valid_i = ($urandom % 3) != 0;
            sel_i       = 3'($urandom);
            amt_i       = 4'($urandom);
            d_in_i      = 8'($urandom);
            ser_in_i    = 1'($urandom);
            abort_i     = ($urandom % 10) == 0;
            if ($urandom % 500 == 0) rst_ni = 1'b0;
            else rst_ni = 1'b1;
        end
        @(negedge clk_i);
        cmd_valid_i = 1'b0; abort_i = 1'b0; rst_ni = 1'b1;
        repeat (3) @(negedge clk_i);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
